// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage: default field widths,
// the default-width payload layout and the occupancy state encoding.
package pipe_pkg;

  localparam int DATA_W    = 32;
  localparam int IMM_W     = 32;
  localparam int JUMP_W    = 11;
  localparam int REG_W     = 5;
  localparam int PAYLOAD_W = 2 * DATA_W + IMM_W + JUMP_W + 2 * REG_W;

  // Field order matches the packing order used by id_ex_pipe (data_a is the MSBs).
  typedef struct packed {
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [IMM_W-1:0]  sign_extend;
    logic [JUMP_W-1:0] jump_dest;
    logic [REG_W-1:0]  reg_dest_r_type;
    logic [REG_W-1:0]  reg_dest_l_type;
  } id_ex_payload_t;

  // Occupancy of the skid variant: nothing, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready register stage with synchronous flush. SKID!=0 builds a
// two-entry stage with a registered in_ready; SKID==0 builds a single entry
// whose in_ready is combinational from out_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_W,
  parameter int SKID  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (SKID != 0) begin : g_skid
      state_t           state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             in_ready_q, in_ready_d;
      logic             in_fire, out_fire;

      assign in_fire  = in_valid & in_ready_q;
      assign out_fire = (state_q != EMPTY) & out_ready;

      // Next occupancy and register loads; flush empties the stage and freezes the payload.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              main_d  = in_data;
              state_d = ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_d = in_data;
            end else if (in_fire) begin
              skid_d  = in_data;
              state_d = TWO;
            end else if (out_fire) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              main_d  = skid_q;
              state_d = ONE;
            end
          end
          default: state_d = EMPTY;
        endcase
        if (flush) begin
          state_d = EMPTY;
          main_d  = main_q;
          skid_d  = skid_q;
        end
        in_ready_d = (state_d != TWO);
      end

      // State, payload and in_ready registers; reset clears everything to a NOP.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          state_q    <= EMPTY;
          main_q     <= '0;
          skid_q     <= '0;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (state_q != EMPTY);
      assign out_data  = main_q;
    end else begin : g_single
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic             in_fire, out_fire;

      assign in_ready = ~valid_q | out_ready;
      assign in_fire  = in_valid & in_ready;
      assign out_fire = valid_q & out_ready;

      // Single-entry update: a new beat replaces the consumed one without a bubble.
      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
          valid_d = 1'b0;
        end else if (in_fire) begin
          valid_d = 1'b1;
          main_d  = in_data;
        end else if (out_fire) begin
          valid_d = 1'b0;
        end
      end

      // Valid flag and payload register.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign out_valid = valid_q;
      assign out_data  = main_q;
    end
  endgenerate

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: packs the decode fields into one vector, passes it
// through a valid/ready stage with flush, and unpacks it for execute.
module id_ex_pipe #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int IMM_W  = pipe_pkg::IMM_W,
  parameter int JUMP_W = pipe_pkg::JUMP_W,
  parameter int REG_W  = pipe_pkg::REG_W,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_a_in,
  input  logic [DATA_W-1:0] data_b_in,
  input  logic [IMM_W-1:0]  sign_extend_in,
  input  logic [JUMP_W-1:0] jump_dest_in,
  input  logic [REG_W-1:0]  reg_dest_r_type_in,
  input  logic [REG_W-1:0]  reg_dest_l_type_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_a_out,
  output logic [DATA_W-1:0] data_b_out,
  output logic [IMM_W-1:0]  sign_extend_out,
  output logic [JUMP_W-1:0] jump_dest_out,
  output logic [REG_W-1:0]  reg_dest_r_type_out,
  output logic [REG_W-1:0]  reg_dest_l_type_out
);

  localparam int PW = 2 * DATA_W + IMM_W + JUMP_W + 2 * REG_W;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;

  assign in_payload = {data_a_in, data_b_in, sign_extend_in, jump_dest_in,
                       reg_dest_r_type_in, reg_dest_l_type_in};

  pipe_skid_reg #(
    .WIDTH(PW),
    .SKID (SKID)
  ) u_stage (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

  assign {data_a_out, data_b_out, sign_extend_out, jump_dest_out,
          reg_dest_r_type_out, reg_dest_l_type_out} = out_payload;

endmodule
